// File: rtl/dac_upsamp_pkg.sv
// -----------------------------------------------------------------------------
// dac_upsamp_pkg
//   Shared definitions for the DAC transmit sample path.
//   - state_t           : interpolator sequencing states (IDLE / RUN / STARVE)
//   - midscale_code()   : offset-binary code for a zero signed sample
//   - to_offset_binary(): signed two's-complement -> offset binary (MSB invert).
//                         Also used by the ADC capture path in the reverse
//                         direction, since the MSB inversion is its own inverse.
//   Both helpers work on a 32-bit container; callers truncate to their width.
// -----------------------------------------------------------------------------
package dac_upsamp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STARVE = 2'd2
  } state_t;

  function automatic logic [31:0] midscale_code(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic logic [31:0] to_offset_binary(input logic [31:0] sample,
                                                   input int unsigned width);
    return sample ^ midscale_code(width);
  endfunction

endpackage

// File: rtl/dac_interp_core.sv
// -----------------------------------------------------------------------------
// dac_interp_core
//   Combinational linear interpolator:
//     v = p + ((n - p) * k) >>> UP_LOG2
//   The difference is carried at DATA_WIDTH+1 bits so full-scale swings do not
//   wrap; the phase is zero-extended so the product stays signed. The result
//   always lies between p and n, so truncating back to DATA_WIDTH is exact.
//
// Ports
//   p  in   DATA_WIDTH signed   previous sample
//   n  in   DATA_WIDTH signed   next sample
//   k  in   KW unsigned         phase within the interpolation period
//   v  out  DATA_WIDTH signed   interpolated sample
// -----------------------------------------------------------------------------
module dac_interp_core #(
  parameter int DATA_WIDTH = 14,
  parameter int UP_LOG2    = 2,
  parameter int KW         = (UP_LOG2 > 0) ? UP_LOG2 : 1
) (
  input  logic signed [DATA_WIDTH-1:0] p,
  input  logic signed [DATA_WIDTH-1:0] n,
  input  logic        [KW-1:0]         k,
  output logic signed [DATA_WIDTH-1:0] v
);

  // One guard bit for the difference, one for the zero-extended phase.
  localparam int PW = DATA_WIDTH + KW + 2;

  logic signed [DATA_WIDTH:0] diff;
  logic signed [PW-1:0]       diff_x;
  logic signed [PW-1:0]       k_x;
  logic signed [PW-1:0]       prod;

  // Arithmetic shift gives floor rounding (toward minus infinity); the
  // magnitude after shifting never exceeds |n - p|, so the narrowing is exact.
  function automatic logic signed [DATA_WIDTH-1:0] floor_scale(
    input logic signed [PW-1:0] x
  );
    return DATA_WIDTH'(x >>> UP_LOG2);
  endfunction

  always_comb begin
    diff   = (DATA_WIDTH+1)'(n) - (DATA_WIDTH+1)'(p);
    diff_x = PW'(diff);
    k_x    = $signed(PW'(k));
    prod   = diff_x * k_x;
    v      = p + floor_scale(prod);
  end

endmodule

// File: rtl/dac_upsamp.sv
// -----------------------------------------------------------------------------
// dac_upsamp
//   Transmit-side sample path. Takes signed samples over an enable/busy
//   handshake into a one-entry buffer, linearly interpolates by 2^UP_LOG2 and
//   emits offset-binary DAC codes once every DAC_DIV clocks. Raises a sticky
//   underrun flag when a period ends with no new sample waiting.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   dataIn        in   DATA_WIDTH signed sample from upstream
//   in_en         in   dataIn valid this cycle
//   inbusy        out  buffer full; a transfer happens on in_en && !inbusy
//   dacdata       out  DATA_WIDTH offset-binary DAC code
//   dac_strobe    out  one-cycle pulse, dacdata updated this cycle
//   underrun      out  sticky starvation flag
//   underrun_clr  in   synchronous clear of underrun (a same-cycle set wins)
// -----------------------------------------------------------------------------
module dac_upsamp
  import dac_upsamp_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int UP_LOG2    = 2,
  parameter int DAC_DIV    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] dataIn,
  input  logic                         in_en,
  output logic                         inbusy,
  output logic        [DATA_WIDTH-1:0] dacdata,
  output logic                         dac_strobe,
  output logic                         underrun,
  input  logic                         underrun_clr
);

  localparam int KW = (UP_LOG2 > 0) ? UP_LOG2 : 1;
  localparam int CW = (DAC_DIV > 1) ? $clog2(DAC_DIV) : 1;

  localparam logic [KW-1:0]         K_LAST   = KW'((1 << UP_LOG2) - 1);
  localparam logic [CW-1:0]         DIV_LAST = CW'(DAC_DIV - 1);
  localparam logic [DATA_WIDTH-1:0] MIDSCALE = DATA_WIDTH'(midscale_code(DATA_WIDTH));

  state_t                         state;
  logic        [CW-1:0]           div_cnt;
  logic        [KW-1:0]           k;
  logic signed [DATA_WIDTH-1:0]   p;
  logic signed [DATA_WIDTH-1:0]   n;
  logic signed [DATA_WIDTH-1:0]   sample_buf;
  logic                           buf_valid;

  logic                           tick;
  logic                           at_boundary;
  logic                           consume;
  logic                           starve_set;
  logic                           accept;
  logic signed [DATA_WIDTH-1:0]   interp_p0;
  logic signed [DATA_WIDTH-1:0]   v_sel_p0;

  logic        [DATA_WIDTH-1:0]   dacdata_p1;
  logic                           vld_p1;

  dac_interp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .UP_LOG2    (UP_LOG2),
    .KW         (KW)
  ) u_interp (
    .p (p),
    .n (n),
    .k (k),
    .v (interp_p0)
  );

  // ---- stage p0: tick decode, handshake and interpolated value ----
  always_comb begin
    tick        = (div_cnt == DIV_LAST);
    // IDLE and STARVE are waiting for a sample, so every tick is a boundary.
    at_boundary = (state != ST_RUN) || (k == K_LAST);
    consume     = tick && buf_valid && at_boundary;
    starve_set  = tick && (state == ST_RUN) && (k == K_LAST) && !buf_valid;
    // Blocked whenever the buffer is full, including the cycle it is consumed,
    // so a consume and an accept never coincide.
    accept      = in_en && !buf_valid;
    v_sel_p0    = (state == ST_IDLE) ? '0 : interp_p0;
  end

  // ---- stage p1: registered code, strobe, sequencing and buffer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      k          <= '0;
      p          <= '0;
      n          <= '0;
      sample_buf <= '0;
      buf_valid  <= 1'b0;
      underrun   <= 1'b0;
      dacdata_p1 <= MIDSCALE;
      vld_p1     <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      vld_p1  <= tick;

      // Output uses p, n, k as they stand before this tick's update.
      if (tick) begin
        dacdata_p1 <= DATA_WIDTH'(to_offset_binary(32'(v_sel_p0), DATA_WIDTH));
      end

      if (accept) begin
        sample_buf <= dataIn;
      end

      if (consume) begin
        buf_valid <= 1'b0;
      end else if (accept) begin
        buf_valid <= 1'b1;
      end

      if (starve_set) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end

      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (buf_valid) begin
              p     <= '0;
              n     <= sample_buf;
              k     <= '0;
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (k == K_LAST) begin
              p <= n;
              k <= '0;
              if (buf_valid) begin
                n <= sample_buf;
              end else begin
                // p == n from here on, so the output holds the last sample.
                state <= ST_STARVE;
              end
            end else begin
              k <= k + KW'(1);
            end
          end
          ST_STARVE: begin
            if (buf_valid) begin
              p     <= n;
              n     <= sample_buf;
              k     <= '0;
              state <= ST_RUN;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign inbusy     = buf_valid;
  assign dacdata    = dacdata_p1;
  assign dac_strobe = vld_p1;

endmodule

// File: tb/tb_dac_upsamp.sv
// -----------------------------------------------------------------------------
// tb_dac_upsamp
//   Bench for dac_upsamp (DATA_WIDTH=14, UP_LOG2=2, DAC_DIV=4). A behavioural
//   model tracks the sample stream with plain integer arithmetic and is
//   compared against the DUT outputs every clock; directed scenarios add
//   literal expectations on the strobe code sequence, followed by a random run.
// -----------------------------------------------------------------------------
module tb_dac_upsamp;

  localparam int DW  = 14;
  localparam int UPL = 2;
  localparam int DIV = 4;
  localparam int F   = 1 << UPL;
  localparam int MID = 1 << (DW - 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] dataIn = '0;
  logic                 in_en = 1'b0;
  logic                 inbusy;
  logic        [DW-1:0] dacdata;
  logic                 dac_strobe;
  logic                 underrun;
  logic                 underrun_clr = 1'b0;

  dac_upsamp #(
    .DATA_WIDTH (DW),
    .UP_LOG2    (UPL),
    .DAC_DIV    (DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dataIn       (dataIn),
    .in_en        (in_en),
    .inbusy       (inbusy),
    .dacdata      (dacdata),
    .dac_strobe   (dac_strobe),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: sample stream view of the interpolator.
  int m_cnt, m_buf, m_p, m_n, m_k, cyc;
  bit m_bufv, m_started, m_starved;
  int exp_dac = MID;
  bit exp_strobe, exp_busy, exp_under;
  int acc_q[$];
  int log_code[$];
  int log_cyc[$];

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_buf = 0; m_p = 0; m_n = 0; m_k = 0; cyc = 0;
    m_bufv = 0; m_started = 0; m_starved = 0;
    exp_dac = MID; exp_strobe = 0; exp_busy = 0; exp_under = 0;
  endtask

  task automatic model_step();
    bit tick, acc, set;
    int v;
    tick = (m_cnt == DIV - 1);
    acc  = in_en && !m_bufv;
    set  = 0;
    cyc++;
    exp_strobe = tick;
    if (tick) begin
      v = m_started ? m_p + floor_div((m_n - m_p) * m_k, F) : 0;
      exp_dac = v + MID;
      if (!m_started || m_starved || m_k == F - 1) begin
        if (m_bufv) begin
          m_p = m_started ? m_n : 0;
          m_n = m_buf;
          m_bufv = 0; m_k = 0; m_started = 1; m_starved = 0;
        end else if (m_started && !m_starved) begin
          m_p = m_n; m_k = 0; m_starved = 1; set = 1;
        end
      end else begin
        m_k++;
      end
    end
    if (set) exp_under = 1;
    else if (underrun_clr) exp_under = 0;
    m_cnt = tick ? 0 : m_cnt + 1;
    if (acc) begin
      m_buf = int'(dataIn);
      m_bufv = 1;
      acc_q.push_back(m_buf);
    end
    exp_busy = m_bufv;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("dacdata",    int'(dacdata),    exp_dac);
      chk("dac_strobe", int'(dac_strobe), int'(exp_strobe));
      chk("inbusy",     int'(inbusy),     int'(exp_busy));
      chk("underrun",   int'(underrun),   int'(exp_under));
      if (dac_strobe) begin
        log_code.push_back(int'(dacdata));
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    in_en = 1'b0;
    underrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    log_code.delete();
    log_cyc.delete();
    acc_q.delete();
  endtask

  task automatic send(input int s);
    int t;
    t = 0;
    @(negedge clk);
    while (inbusy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (inbusy) chk("send_timeout", int'(inbusy), 0);
    dataIn = DW'(s);
    in_en = 1'b1;
    @(negedge clk);
    in_en = 1'b0;
  endtask

  task automatic wait_strobes(input int cnt, input string nm);
    int t;
    t = 0;
    while (log_code.size() < cnt && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (log_code.size() < cnt) chk({nm, "_strobe_timeout"}, log_code.size(), cnt);
  endtask

  task automatic chk_log(input int idx, input int exp, input string nm);
    if (log_code.size() > idx) chk(nm, log_code[idx], exp);
    else                       chk({nm, "_missing"}, -1, exp);
  endtask

  int exp2[9] = '{8192, 8192, 8292, 8392, 8492, 8592, 8392, 8192, 7992};
  int vals[30];

  initial begin
    int first_other, sent, busy_seen, diff, t;
    bit free;
    model_reset();

    // 1: idle after reset
    do_reset();
    wait_strobes(3, "t1");
    for (int i = 0; i < 3; i++) chk_log(i, MID, "t1_idle_code");
    if (log_cyc.size() >= 2) begin
      chk("t1_first_strobe_cycle", log_cyc[0], 4);
      chk("t1_strobe_spacing", log_cyc[1] - log_cyc[0], DIV);
    end else chk("t1_strobe_cycles_missing", log_cyc.size(), 2);
    chk("t1_underrun", int'(underrun), 0);
    chk("t1_inbusy", int'(inbusy), 0);

    // 2: ramp 0 -> 400 -> -400
    do_reset();
    send(400);
    send(-400);
    wait_strobes(9, "t2");
    for (int i = 0; i < 9; i++) chk_log(i, exp2[i], "t2_ramp_code");

    // 3: starve then resume, clear flag
    do_reset();
    send(400);
    wait_strobes(8, "t3");
    chk_log(7, 8592, "t3_hold_code");
    chk("t3_underrun_set", int'(underrun), 1);
    log_code.delete();
    log_cyc.delete();
    send(-400);
    first_other = -1;
    for (int i = 0; i < 8 && first_other < 0; i++) begin
      wait_strobes(i + 1, "t3b");
      if (log_code.size() > i && log_code[i] != 8592) first_other = log_code[i];
    end
    chk("t3_resume_code", first_other, 8392);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("t3_underrun_cleared", int'(underrun), 0);

    // 4: in_en held high, scoreboard of accepted samples
    do_reset();
    foreach (vals[i]) vals[i] = int'($urandom_range(16383)) - MID;
    sent = 0; busy_seen = 0; t = 0;
    dataIn = DW'(vals[0]);
    in_en = 1'b1;
    free = !inbusy;
    while (sent < 30 && t < 2000) begin
      @(negedge clk);
      t++;
      if (free) sent++;
      if (sent < 30) dataIn = DW'(vals[sent]);
      else           in_en = 1'b0;
      if (inbusy) busy_seen++;
      free = !inbusy && (sent < 30);
    end
    in_en = 1'b0;
    chk("t4_sent", sent, 30);
    chk("t4_acc_count", acc_q.size(), 30);
    for (int j = 0; j < 30; j++) begin
      if (acc_q.size() > j) chk("t4_acc_order", acc_q[j], vals[j]);
    end
    diff = sent * F - log_code.size();
    chk("t4_rate", int'(diff >= -F && diff <= 2 * F), 1);
    chk("t4_busy_seen", int'(busy_seen > 0), 1);

    // 5: extremes and negative-difference rounding
    do_reset();
    send(-8192);
    send(8191);
    wait_strobes(9, "t5a");
    chk_log(5, 0,     "t5_full_k0");
    chk_log(6, 4095,  "t5_full_k1");
    chk_log(7, 8191,  "t5_full_k2");
    chk_log(8, 12287, "t5_full_k3");
    do_reset();
    send(0);
    send(-1);
    wait_strobes(9, "t5b");
    chk_log(5, 8192, "t5_round_k0");
    chk_log(6, 8191, "t5_round_k1");
    chk_log(7, 8191, "t5_round_k2");
    chk_log(8, 8191, "t5_round_k3");

    // 6: asynchronous reset while a sample is buffered
    do_reset();
    send(100);
    send(200);
    wait_strobes(3, "t6");
    chk("t6_busy_before", int'(inbusy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_dacdata", int'(dacdata), MID);
    chk("t6_async_strobe", int'(dac_strobe), 0);
    chk("t6_async_inbusy", int'(inbusy), 0);
    chk("t6_async_underrun", int'(underrun), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    log_code.delete();
    log_cyc.delete();
    wait_strobes(6, "t6b");
    for (int i = 0; i < 6; i++) chk_log(i, MID, "t6_idle_after_reset");

    // 7: random traffic at varying rates
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      in_en        = (i < 400) ? ($urandom_range(3) != 0) : ($urandom_range(19) == 0);
      dataIn       = DW'(int'($urandom_range(16383)) - MID);
      underrun_clr = ($urandom_range(15) == 0);
    end
    @(negedge clk);
    in_en = 1'b0;
    underrun_clr = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_upsamp.md
# dac_upsamp

Transmit-side sample path for the DAC. Accepts signed two's-complement samples from the processing chain over an enable/busy handshake, and linearly interpolates by 2^UP_LOG2. Emits offset-binary DAC codes at a fixed clock-divided rate and flags underrun when the upstream cannot keep pace. This block is the DAC-direction counterpart of the ADC capture path, which converts offset binary to signed.

## Interface
- DATA_WIDTH, 14, sample width for input and DAC code
- UP_LOG2, 2, interpolation factor F = 2^UP_LOG2, range 0..4
- DAC_DIV, 4, clk cycles per DAC output, ≥1
- clk  input  1  single system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- dataIn  input  DATA_WIDTH  signed sample from upstream
- in_en  input  1  upstream presents a valid dataIn this cycle
- inbusy  output  1  block cannot accept; a sample transfers on in_en && !inbusy
- dacdata  output  DATA_WIDTH  offset-binary DAC code (signed with MSB inverted)
- dac_strobe  output  1  one-cycle pulse; dacdata is new this cycle
- underrun  output  1  sticky; set when the block starves
- underrun_clr  input  1  synchronous clear of underrun

## Operation
- Registers:
  - buf plus buf_valid: one-entry input buffer.
  - p and n: previous and next signed samples.
  - k: phase, UP_LOG2 bits.
  - div_cnt: counts 0..DAC_DIV-1.
- inbusy = buf_valid, driven directly from the register. Accepting sets buf_valid and loads buf.
- tick = (div_cnt == DAC_DIV-1); div_cnt wraps on tick and runs in every state.
- Interpolated value v = p + ((n − p) · k) >>> UP_LOG2.
  - Difference is DATA_WIDTH+1 bits signed; product is DATA_WIDTH+1+UP_LOG2 bits.
  - The shift is arithmetic, so rounding is toward −∞.
  - v always lies in [min(p,n), max(p,n)], so it is truncated to DATA_WIDTH with no saturation.
- On tick: dacdata <= {~v[MSB], v[MSB-1:0]}, computed from pre-update p, n, k. dac_strobe <= 1. Otherwise dac_strobe <= 0.
- State machine:
  - IDLE: v forced to 0, so output is midscale. On tick with buf_valid: p<=0, n<=buf, clear buf_valid, k<=0, go to RUN.
  - RUN: on tick, k<=k+1.
    - At k==F−1 with buf_valid: p<=n, n<=buf, clear buf_valid, k<=0.
    - At k==F−1 without buf_valid: p<=n, k<=0, set underrun, go to STARVE.
  - STARVE: p==n, so output holds n. On tick with buf_valid: p<=n, n<=buf, clear buf_valid, k<=0, go to RUN. Otherwise stay.
- Accept and consume in the same cycle: the consume clears buf_valid. The accept is blocked because inbusy was 1, so no sample is lost or duplicated.
- underrun_clr and a set in the same cycle: the set wins.
- UP_LOG2 = 0: every tick consumes a sample, and v = p on each tick.

## Timing
- Reset values:
  - dacdata = 1<<(DATA_WIDTH−1) (midscale); dac_strobe = 0; inbusy = 0; underrun = 0.
  - State = IDLE; p = n = 0; k = 0; div_cnt = 0.
- Reset asserted mid-operation clears everything immediately and discards any buffered sample.
- dac_strobe is high for exactly 1 cycle, every DAC_DIV cycles, starting DAC_DIV cycles after reset release.
- Latency: a sample accepted at cycle t is loaded into n on the first tick at a phase boundary. Its value first fully appears as p at the next period start, F ticks later.
- Sustained throughput without underrun requires one sample per F·DAC_DIV cycles.

## Structure
- Shared package: the state enum (IDLE/RUN/STARVE), the offset-binary conversion function (shared with the ADC path), and the midscale constant.
- One sub-module, dac_interp_core: combinational v from p, n, k with the width rules above.
- The FSM, buffer and divider live at top level.

## Test plan
All cases use DATA_WIDTH=14, UP_LOG2=2, DAC_DIV=4 unless noted.
1. Reset release, no input → strobe every 4 cycles, dacdata = 8192, underrun = 0, inbusy = 0.
2. Feed 400 then −400 at sufficient rate → dacdata codes 8192, 8292, 8392, 8492, then 8592, 8392, 8192, 7992.
3. Feed one sample 400, then stop → after the ramp, dacdata holds 8592 and underrun = 1. Next sample −400 resumes interpolation from 400. underrun_clr drops the flag.
4. Hold in_en high continuously → inbusy high between consumes. Exactly one sample is accepted per F ticks, with no loss or duplication (checked by a scoreboard).
5. Extremes: p = −8192, n = 8191 → phase-3 output is 4095 signed, code 12287, with no overflow. Negative-diff rounding, p = 0 and n = −1 → codes 8192, 8191, 8191, 8191.
6. Assert rst_n low mid-RUN with buf_valid = 1 → outputs return to reset values asynchronously. After release the block is back in IDLE and the buffered sample is gone.
